// File: rtl/lsu_pkg.sv
// lsu_pkg: FSM state encoding and byte-enable constants for the LSU.
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;
endpackage

// File: rtl/define.sv
// define.sv: shared access-width codes used by the decode path and the LSU.
`ifndef LSU_DEFINE_SV
`define LSU_DEFINE_SV
`define MEM_B  3'b000
`define MEM_H  3'b001
`define MEM_W  3'b010
`define MEM_BU 3'b100
`define MEM_HU 3'b101
`endif

// File: rtl/lsu_extend.sv
// lsu_extend: selects the addressed lane of a read word and sign/zero-extends it.
`include "define.sv"
module lsu_extend (
   input  logic [2:0]  ctrl,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b    = rdata[{off, 3'b000} +: 8];
      h    = off[1] ? rdata[31:16] : rdata[15:0];
      data = ctrl == `MEM_B  ? {{24{b[7]}}, b} :
             ctrl == `MEM_BU ? {24'b0, b} :
             ctrl == `MEM_H  ? {{16{h[15]}}, h} :
             ctrl == `MEM_HU ? {16'b0, h} : rdata;
   end
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit bridging the pipeline to a req/ack bus with timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
`include "define.sv"
module lsu
   import lsu_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  mem_ctrl_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        fault_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);
   state_t      state, state_nx;
   logic [31:0] cnt;
   logic [2:0]  ctrl_q;
   logic [1:0]  off_q;
   logic [31:0] ext;
   logic        req, hw, bt, mis, tmo;
   logic [3:0]  be;
   logic [31:0] wd;

   assign req = mem_read_i | mem_write_i;
   assign hw  = mem_ctrl_i == `MEM_H || mem_ctrl_i == `MEM_HU;
   assign bt  = mem_ctrl_i == `MEM_B || mem_ctrl_i == `MEM_BU;
`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = hw ? addr_i[0] : !bt && addr_i[1:0] != 2'b00;
`else
   assign mis = 1'b0;
`endif
   // undefined width codes fall through to full-word behaviour
   assign be  = bt ? BE_B << addr_i[1:0] : hw ? BE_H << {addr_i[1], 1'b0} : BE_W;
   assign wd  = bt ? {4{wdata_i[7:0]}} : hw ? {2{wdata_i[15:0]}} : wdata_i;
   assign tmo = cnt == 32'(WAIT_TIMEOUT - 1);

   lsu_extend u_ext (
      .ctrl  (ctrl_q),
      .off   (off_q),
      .rdata (bus_rdata_i),
      .data  (ext)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      busy_o   = state == REQ || (state == IDLE && req);
      done_o   = state == RESP;
      state_nx = state == IDLE ? (req ? (mis ? RESP : REQ) : IDLE) :
                 state == REQ  ? (bus_ack_i || tmo ? RESP : REQ) : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt         <= '0;
         ctrl_q      <= '0;
         off_q       <= '0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
         fault_o     <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
      end else if (state == IDLE && req) begin
         cnt         <= '0;
         ctrl_q      <= mem_ctrl_i;
         off_q       <= addr_i[1:0];
         fault_o     <= mis;
         bus_req_o   <= !mis;
         bus_we_o    <= mem_write_i;
         bus_addr_o  <= {addr_i[31:2], 2'b00};
         bus_be_o    <= be;
         bus_wdata_o <= wd;
      end else if (state == REQ) begin
         cnt <= cnt + 32'd1;
         if (bus_ack_i || tmo) begin
            bus_req_o <= 1'b0;
            err_o     <= !bus_ack_i;
            rdata_o   <= bus_ack_i && !bus_we_o ? ext : '0;
         end
      end else if (state == RESP) begin
         rdata_o <= '0;
         err_o   <= 1'b0;
         fault_o <= 1'b0;
      end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu against a behavioural access model.
`include "define.sv"
module tb_lsu;
   localparam int WT = 16;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        mem_read_i = 0, mem_write_i = 0, bus_ack_i = 0;
   logic [2:0]  mem_ctrl_i = 0;
   logic [31:0] addr_i = 0, wdata_i = 0, bus_rdata_i = 0;
   logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
   logic        busy_o, done_o, err_o, fault_o, bus_req_o, bus_we_o;
   logic [3:0]  bus_be_o;

   int n_chk = 0, n_err = 0;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;
   logic        exp_we, exp_err, exp_fault;
   logic [31:0] last_addr, last_wdata, last_rdata;
   logic [3:0]  last_be;
   logic        last_we, last_err, last_fault, seen_req;
   int          last_lat;

   lsu #(.WAIT_TIMEOUT(WT)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .mem_ctrl_i(mem_ctrl_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .fault_o(fault_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
      .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int m_width(input logic [2:0] c);
      return (c == `MEM_B || c == `MEM_BU) ? 1 : (c == `MEM_H || c == `MEM_HU) ? 2 : 4;
   endfunction

   function automatic int m_off(input logic [2:0] c, input logic [31:0] a);
      int w = m_width(c);
      return w == 4 ? 0 : (int'(a % 4) / w) * w;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] c, input logic [31:0] a);
      int w = m_width(c);
      return w == 4 ? 4'hF : 4'(((1 << w) - 1) << m_off(c, a));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] c, input logic [31:0] d);
      int w = m_width(c);
      return w == 1 ? {24'b0, d[7:0]} * 32'h01010101 :
             w == 2 ? {16'b0, d[15:0]} * 32'h00010001 : d;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
      int w = m_width(c);
      logic [31:0] v, mask;
      if (w == 4) return d;
      mask = (32'd1 << (8 * w)) - 32'd1;
      v    = (d >> (8 * m_off(c, a))) & mask;
      if ((c == `MEM_B || c == `MEM_H) && v[8*w-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit m_mis(input logic [2:0] c, input logic [31:0] a);
      int w = m_width(c);
      return TRAP && w > 1 && (a % w) != 0;
   endfunction

   always @(negedge clk) if (rst_n) begin
      if (bus_req_o) begin
         seen_req   = 1'b1;
         last_addr  = bus_addr_o;
         last_be    = bus_be_o;
         last_we    = bus_we_o;
         last_wdata = bus_wdata_o;
         chk("bus_addr", bus_addr_o, exp_addr);
         chk("bus_be", {28'b0, bus_be_o}, {28'b0, exp_be});
         chk("bus_we", {31'b0, bus_we_o}, {31'b0, exp_we});
         chk("bus_wdata", bus_wdata_o, exp_wdata);
      end
      if (done_o) begin
         last_rdata = rdata_o;
         last_err   = err_o;
         last_fault = fault_o;
         chk("rdata", rdata_o, exp_rdata);
         chk("err", {31'b0, err_o}, {31'b0, exp_err});
         chk("fault", {31'b0, fault_o}, {31'b0, exp_fault});
      end
   end

   // ack_dly: REQ cycles before ack (0 = first REQ cycle), negative = never ack
   task automatic run(input logic rd, input logic wr, input logic [2:0] c, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rdat, input int ack_dly);
      int  k = 0, lat;
      bit  mis = m_mis(c, a), fin = 0;
      exp_we    = wr;
      exp_addr  = a & ~32'd3;
      exp_be    = m_be(c, a);
      exp_wdata = m_wdata(c, wd);
      exp_fault = mis;
      exp_err   = !mis && ack_dly < 0;
      exp_rdata = (wr || mis || ack_dly < 0) ? 32'd0 : m_load(c, a, rdat);
      lat       = mis ? 1 : ack_dly < 0 ? WT + 1 : ack_dly + 2;
      seen_req  = 0;
      last_addr = 32'hDEAD_BEEF;
      last_be   = 4'h0;
      @(negedge clk);
      mem_read_i = rd; mem_write_i = wr; mem_ctrl_i = c; addr_i = a; wdata_i = wd;
      #1 chk("busy_req", {31'b0, busy_o}, 32'd1);
      @(posedge clk);
      #1 mem_read_i = 0; mem_write_i = 0;
      while (!fin && k < 40) begin
         @(negedge clk);
         #1 k++;
         if (done_o) begin
            fin = 1;
            bus_ack_i = 0;
         end else begin
            chk("busy_wait", {31'b0, busy_o}, 32'd1);
            chk("req_on", {31'b0, bus_req_o}, {31'b0, !mis});
            bus_ack_i   = (k - 1 == ack_dly);
            bus_rdata_i = bus_ack_i ? rdat : $urandom;
         end
      end
      last_lat = k;
      chk("latency", k, lat);
      @(negedge clk);
      #1 chk("idle_done", {31'b0, done_o}, 32'd0);
      chk("idle_busy", {31'b0, busy_o}, 32'd0);
      chk("idle_req", {31'b0, bus_req_o}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 chk("rst_state", {rdata_o}, 32'd0);
      chk("rst_bus", {bus_addr_o | bus_wdata_o}, 32'd0);
      chk("rst_flags", {24'b0, bus_be_o, bus_req_o, bus_we_o, done_o, err_o | fault_o}, 32'd0);
      @(negedge clk) rst_n = 1;

      run(1, 0, `MEM_B, 32'h103, 32'h0, 32'h80FF1234, 0);
      chk("lb_addr", last_addr, 32'h100);
      chk("lb_be", {28'b0, last_be}, 32'h8);
      chk("lb_rdata", last_rdata, 32'hFFFFFF80);
      chk("lb_lat", last_lat, 2);

      run(0, 1, `MEM_H, 32'h202, 32'h0000ABCD, 32'h5555AAAA, 1);
      chk("sh_we", {31'b0, last_we}, 32'd1);
      chk("sh_be", {28'b0, last_be}, 32'hC);
      chk("sh_wdata", last_wdata, 32'hABCDABCD);
      chk("sh_rdata", last_rdata, 32'd0);

      run(1, 0, `MEM_H, 32'h0, 32'h0, 32'h00008001, 3);
      chk("lh_rdata", last_rdata, 32'hFFFF8001);
      run(1, 0, `MEM_HU, 32'h0, 32'h0, 32'h00008001, 3);
      chk("lhu_rdata", last_rdata, 32'h00008001);

      run(1, 0, `MEM_W, 32'h400, 32'h0, 32'h12345678, -1);
      chk("tmo_err", {31'b0, last_err}, 32'd1);
      chk("tmo_rdata", last_rdata, 32'd0);
      chk("tmo_lat", last_lat, WT + 1);

      run(1, 0, `MEM_W, 32'h101, 32'h0, 32'hCAFEF00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_mis_fault", {31'b0, last_fault}, 32'd1);
      chk("lw_mis_noreq", {31'b0, seen_req}, 32'd0);
`else
      chk("lw_mis_addr", last_addr, 32'h100);
      chk("lw_mis_be", {28'b0, last_be}, 32'hF);
      chk("lw_mis_rdata", last_rdata, 32'hCAFEF00D);
`endif

      run(0, 1, `MEM_B, 32'h001, 32'h123456A5, 32'h0, 2);
      chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
      chk("sb_be", {28'b0, last_be}, 32'h2);
      run(0, 1, `MEM_W, 32'h10, 32'hDEADBEEF, 32'h0, 1);
      run(1, 1, `MEM_W, 32'h20, 32'h01020304, 32'hFFFFFFFF, 0);
      chk("rw_is_store", {31'b0, last_we}, 32'd1);
      run(1, 0, `MEM_BU, 32'h102, 32'h0, 32'h00800000, 0);
      chk("lbu_rdata", last_rdata, 32'h00000080);
      run(1, 0, 3'b011, 32'h8, 32'h0, 32'h87654321, 1);
      run(1, 0, `MEM_H, 32'h203, 32'h0, 32'hC0DE1111, 0);

      // reset in the 2nd REQ cycle with an ack pending
      exp_addr = 32'h40; exp_be = 4'hF; exp_we = 0; exp_wdata = 32'h0;
      @(negedge clk);
      mem_read_i = 1; mem_ctrl_i = `MEM_W; addr_i = 32'h40; wdata_i = 0;
      @(posedge clk);
      #1 mem_read_i = 0;
      repeat (2) @(negedge clk);
      #2 chk("rst_pre_req", {31'b0, bus_req_o}, 32'd1);
      bus_ack_i = 1; bus_rdata_i = 32'h11111111; rst_n = 0;
      #1 chk("rst_req_drop", {31'b0, bus_req_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_mid_data", rdata_o | bus_addr_o | bus_wdata_o, 32'd0);
      chk("rst_mid_flags", {26'b0, bus_be_o, bus_we_o, done_o, err_o | fault_o}, 32'd0);
      @(posedge clk);
      #1 bus_ack_i = 0;
      @(negedge clk) rst_n = 1;
      run(1, 0, `MEM_W, 32'h44, 32'h0, 32'h0BADF00D, 1);
      chk("post_rst_rdata", last_rdata, 32'h0BADF00D);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
